// File: rtl/rand_sched_pkg.sv
// Shared types and constants for the rand_sched random-value scheduler.
// Holds the FSM state encoding and the LFSR step rule used by the datapath.
package rand_sched_pkg;

  localparam int LFSR_W     = 4;
  localparam int ROLL_LIMIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROLL  = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  // XNOR-feedback shift: the all-zero reset value is a legal member of the sequence.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[2:0], ~(q[3] ^ q[2])};
  endfunction

endpackage

// File: rtl/rand_sched_if.sv
// Request/grant bundle between requesters and the rand_sched generator.
// The master side drives requests; the slave side (the scheduler) answers.
interface rand_sched_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic             valid;
  logic [3:0]       rand_out;
  logic             err;
  logic             busy;

  modport master (
    output req,
    input  grant, valid, rand_out, err, busy
  );

  modport slave (
    input  req,
    output grant, valid, rand_out, err, busy
  );

endinterface

// File: rtl/rand_sched_lfsr.sv
// 4-bit XNOR LFSR that advances one position per cycle while step is high.
// Reset value is all-zero; the all-ones lock-up state is never reached from it.
module lfsr4_step
  import rand_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else if (step) begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/rand_sched.sv
// Round-robin scheduler handing out bounded, non-repeating LFSR values.
// One requester is served per IDLE -> ROLL -> GRANT pass; a stuck roll falls back after a limit.
module rand_sched
  import rand_sched_pkg::*;
#(
  parameter int                N_REQ     = 4,
  parameter logic [LFSR_W-1:0] MAX_VAL   = 4'd9,
  parameter bit                NO_REPEAT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  rand_sched_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  winner_q, winner_d;
  logic [PTR_W-1:0]  pick;
  logic [3:0]        roll_cnt_q, roll_cnt_d;
  logic [LFSR_W-1:0] rand_q, rand_d;
  logic              err_q, err_d;
  logic [LFSR_W-1:0] last_q, last_d;
  logic              have_last_q, have_last_d;

  logic              lfsr_step;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] roll_val;
  logic              any_req;
  logic              winner_held;
  logic              accept;
  logic              limit_hit;

  logic [N_REQ-1:0]  grant_c;
  logic              valid_c;
  logic              err_c;
  logic              busy_c;

  lfsr4_step u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (lfsr_step),
    .q       (lfsr_q)
  );

  // The value judged in a ROLL cycle is the one the LFSR is stepping into.
  assign lfsr_step   = (state_q == ST_ROLL);
  assign roll_val    = lfsr_next(lfsr_q);
  assign any_req     = |bus.req;
  assign winner_held = bus.req[winner_q];
  assign limit_hit   = (roll_cnt_q == 4'(ROLL_LIMIT - 1));
  assign accept      = (roll_val <= MAX_VAL) &&
                       (!NO_REPEAT || !have_last_q || (roll_val != last_q));

  // Two passes: the second (indices at or above ptr) overrides the wrapped first pass.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (PTR_W'(i) < ptr_q)) pick = PTR_W'(i);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (PTR_W'(i) >= ptr_q)) pick = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) state_d = ST_ROLL;
      end
      ST_ROLL: begin
        if (!winner_held)            state_d = ST_IDLE;
        else if (accept || limit_hit) state_d = ST_GRANT;
      end
      ST_GRANT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_c = '0;
    valid_c = 1'b0;
    err_c   = 1'b0;
    busy_c  = (state_q != ST_IDLE);
    if (state_q == ST_GRANT) begin
      grant_c[winner_q] = 1'b1;
      valid_c           = 1'b1;
      err_c             = err_q;
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    roll_cnt_d  = roll_cnt_q;
    rand_d      = rand_q;
    err_d       = err_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          winner_d   = pick;
          roll_cnt_d = '0;
        end
      end
      ST_ROLL: begin
        roll_cnt_d = roll_cnt_q + 4'd1;
        if (winner_held && (accept || limit_hit)) begin
          rand_d = roll_val;
          err_d  = !accept;
        end
      end
      ST_GRANT: begin
        last_d      = rand_q;
        have_last_d = 1'b1;
        ptr_d       = (winner_q == PTR_W'(N_REQ - 1)) ? '0 : winner_q + PTR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      winner_q    <= '0;
      roll_cnt_q  <= '0;
      rand_q      <= '0;
      err_q       <= 1'b0;
      last_q      <= '0;
      have_last_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      roll_cnt_q  <= roll_cnt_d;
      rand_q      <= rand_d;
      err_q       <= err_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
    end
  end

  assign bus.grant    = grant_c;
  assign bus.valid    = valid_c;
  assign bus.err      = err_c;
  assign bus.busy     = busy_c;
  assign bus.rand_out = rand_q;

endmodule

// File: doc/rand_sched.md
RAND_SCHED -- requirements
Module: rand_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing the generator.
REQ-002 SHALL have parameter MAX_VAL, default 4'd9: largest value that may be issued.
REQ-003 SHALL have parameter NO_REPEAT, default 1: when 1, a value equal to the last issued value is rejected.
REQ-004 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  N_REQ  level request per requester; held until grant or abandoned.
REQ-007 SHALL have port grant  output  N_REQ  one-hot; one-cycle pulse to the served requester.
REQ-008 SHALL have port valid  output  1  high exactly when grant is nonzero.
REQ-009 SHALL have port rand_out  output  4  issued value; meaningful only while valid=1, otherwise holds the last issued value.
REQ-010 SHALL have port err  output  1  pulses with valid when the issued value came from roll-limit fallback.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL hold a 4-bit LFSR that steps only in ROLL: next = {q[2:0], ~(q[3]^q[2])}.
REQ-013 SHALL implement the FSM IDLE -> ROLL -> GRANT -> IDLE.
REQ-014 In IDLE with req!=0, SHALL pick the winner round-robin, starting at pointer ptr, latch it, clear the roll counter and move to ROLL.
REQ-015 In ROLL, SHALL step the LFSR once per cycle and increment the 4-bit roll counter.
REQ-016 SHALL accept a new LFSR value when value<=MAX_VAL and (NO_REPEAT==0, or no value has yet been issued, or value!=last issued).
REQ-017 On acceptance, SHALL register rand_out=value and go to GRANT with err=0.
REQ-018 On the 15th consecutive rejection, SHALL register rand_out=that 15th value, set err=1 and go to GRANT.
REQ-019 In GRANT, SHALL assert grant[winner] and valid for exactly one cycle, update last issued, set ptr=winner+1 mod N_REQ, then return to IDLE.
REQ-020 If req[winner] falls while in ROLL, SHALL return to IDLE with no grant and leave ptr and last issued unchanged; the LFSR keeps its advanced state.
REQ-021 Minimum latency SHALL be exactly 2 cycles, from the IDLE sample of req to the grant cycle; each extra rejected roll adds 1 cycle.
REQ-022 Requests arriving while busy=1 SHALL only be considered at the next IDLE cycle; IDLE SHALL never be skipped between grants.
REQ-023 With simultaneous requests, the lowest index at or after ptr (wrapping) SHALL win.

Reset
REQ-024 On reset_n low, the block SHALL immediately force: state=IDLE, LFSR=4'b0000, ptr=0, roll counter=0, last-issued flag cleared, and grant=0, valid=0, err=0, busy=0, rand_out=4'd0.
REQ-025 Reset asserted in any state SHALL abort the operation with no grant issued.

Structure
REQ-026 Shared package rand_sched_pkg SHALL hold the FSM state enum and the constants LFSR_W=4 and ROLL_LIMIT=15.
REQ-027 The LFSR SHALL be a separate sub-module lfsr4_step with ports clk, reset_n, step and q[3:0], reset value 0000.

Verification
REQ-028 After reset, MAX_VAL=9, req=0001 raised at cycle 0 -> grant=0001, valid=1, rand_out=1 at cycle 2.
REQ-029 Then req=0011 held -> next grant=0010 with rand_out=3, then grant=0001 with rand_out=7; each grant arrives 3 cycles after the previous one.
REQ-030 Continuing -> rolls 14, 13 and 11 are rejected and 6 is accepted; that grant comes 3 cycles later than the minimum latency.
REQ-031 MAX_VAL=0, NO_REPEAT=1, two requests in sequence -> first grant gives rand_out=0, err=0 after 15 rolls; second gives rand_out=0, err=1 after 15 rolls.
REQ-032 Winner's req dropped during ROLL, or reset_n pulsed mid-ROLL -> no grant and busy=0 next cycle; after the reset, the next request issues rand_out=1 again.
